// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - E-stage issue/hazard controller for a multi-cycle multiply/divide unit
// Launches mult/div/move ops, stalls dependent reads until the unit is idle, and tracks latency and timeouts.
module muldiv_issue_ctrl #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        e_valid,
   input  logic [3:0]  e_op,
   input  logic [31:0] e_rs,
   input  logic [31:0] e_rt,
   input  logic        e_flush,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_hi,
   input  logic [31:0] mdu_lo,
   output logic [3:0]  mdu_op,
   output logic [31:0] mdu_a,
   output logic [31:0] mdu_b,
   output logic        stall,
   output logic        mf_valid,
   output logic [31:0] mf_data,
   output logic        timeout,
   output logic [4:0]  last_lat
);

   // Counter must hold MAX_WAIT+1 and be at least as wide as last_lat.
   localparam int CW = ($clog2(MAX_WAIT + 2) > 5) ? $clog2(MAX_WAIT + 2) : 5;
   localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    mdu_op_q, mdu_op_d;
   logic [31:0]   mdu_a_q, mdu_a_d;
   logic [31:0]   mdu_b_q, mdu_b_d;
   logic          mf_valid_q, mf_valid_d;
   logic [31:0]   mf_data_q, mf_data_d;
   logic          timeout_q, timeout_d;
   logic [4:0]    last_lat_q, last_lat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          age_q, age_d;

   logic          op_known;
   logic          op_read;
   logic          accept;
   logic          issued_move;
   logic [CW-1:0] cnt_inc;
   logic [4:0]    lat_sat;

   assign op_known    = (e_op >= 4'd1) && (e_op <= 4'd8);
   assign op_read     = (e_op == 4'd7) || (e_op == 4'd8);
   assign accept      = (state_q == IDLE) && e_valid && op_known && !e_flush && !mdu_busy;
   assign issued_move = (mdu_op_q == 4'd5) || (mdu_op_q == 4'd6);
   assign cnt_inc     = cnt_q + 1'b1;
   assign lat_sat     = (cnt_q > CW'(31)) ? 5'd31 : cnt_q[4:0];

   // A flushed instruction never holds the pipeline.
   assign stall = e_valid && op_known && !e_flush && ((state_q != IDLE) || mdu_busy);

   always_comb begin
      state_d    = state_q;
      mdu_op_d   = 4'd0;
      mdu_a_d    = mdu_a_q;
      mdu_b_d    = mdu_b_q;
      mf_valid_d = 1'b0;
      mf_data_d  = mf_data_q;
      timeout_d  = timeout_q;
      last_lat_d = last_lat_q;
      cnt_d      = cnt_q;
      age_d      = age_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op_read) begin
                  mf_valid_d = 1'b1;
                  mf_data_d  = (e_op == 4'd7) ? mdu_hi : mdu_lo;
               end else begin
                  state_d  = ISSUE;
                  mdu_op_d = e_op;
                  mdu_a_d  = e_rs;
                  mdu_b_d  = e_rt;
                  cnt_d    = '0;
                  age_d    = 1'b0;
               end
            end
         end
         ISSUE: begin
            if (issued_move) begin
               state_d = IDLE;
            end else begin
               // The unit may raise busy as soon as it sees the op; that cycle counts.
               state_d = WAIT;
               if (mdu_busy) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc > MAX_W) begin
                     timeout_d = 1'b1;
                     state_d   = DONE;
                  end
               end
            end
         end
         WAIT: begin
            age_d = 1'b1;
            if (mdu_busy) begin
               cnt_d = cnt_inc;
               if (cnt_inc > MAX_W) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end
            end else if (cnt_q != '0) begin
               last_lat_d = lat_sat;
               state_d    = DONE;
            end else if (age_q) begin
               // Busy never rose: the unit finished without a visible busy window.
               last_lat_d = 5'd0;
               state_d    = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         mdu_op_q   <= 4'd0;
         mdu_a_q    <= 32'd0;
         mdu_b_q    <= 32'd0;
         mf_valid_q <= 1'b0;
         mf_data_q  <= 32'd0;
         timeout_q  <= 1'b0;
         last_lat_q <= 5'd0;
         cnt_q      <= '0;
         age_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mdu_op_q   <= mdu_op_d;
         mdu_a_q    <= mdu_a_d;
         mdu_b_q    <= mdu_b_d;
         mf_valid_q <= mf_valid_d;
         mf_data_q  <= mf_data_d;
         timeout_q  <= timeout_d;
         last_lat_q <= last_lat_d;
         cnt_q      <= cnt_d;
         age_q      <= age_d;
      end
   end

   assign mdu_op   = mdu_op_q;
   assign mdu_a    = mdu_a_q;
   assign mdu_b    = mdu_b_q;
   assign mf_valid = mf_valid_q;
   assign mf_data  = mf_data_q;
   assign timeout  = timeout_q;
   assign last_lat = last_lat_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb/tb_muldiv_issue_ctrl.sv - scoreboard bench for muldiv_issue_ctrl with a behavioural multiply/divide unit
module tb_muldiv_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_valid;
   logic [3:0]  e_op;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        e_flush;
   logic        mdu_busy;
   logic [31:0] mdu_hi;
   logic [31:0] mdu_lo;
   logic [3:0]  mdu_op;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   logic        stall;
   logic        mf_valid;
   logic [31:0] mf_data;
   logic        timeout;
   logic [4:0]  last_lat;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } iss_t;

   iss_t        exp_iss[$];
   logic [31:0] exp_mf[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          next_lat = 0;
   int          busy_left = 0;
   logic [31:0] pend_hi, pend_lo;

   muldiv_issue_ctrl #(.MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
      .e_flush(e_flush), .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
      .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b), .stall(stall), .mf_valid(mf_valid),
      .mf_data(mf_data), .timeout(timeout), .last_lat(last_lat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Present an op at posedge+2, hold it until accepted, return the number of stalled cycles.
   task automatic issue_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           output int stalls);
      e_valid = 1'b1; e_op = op; e_rs = rs; e_rt = rt; stalls = 0;
      @(negedge clk);
      while (stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stall) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: op %0d still stalled after %0d cycles", op, stalls);
      end
      @(posedge clk);
      #2;
      e_valid = 1'b0; e_op = 4'd0;
   endtask

   // Multiply/divide unit: busy rises in the cycle the op is presented and lasts next_lat cycles.
   initial begin
      mdu_busy = 1'b0; mdu_hi = 32'd0; mdu_lo = 32'd0;
      pend_hi = 32'd0; pend_lo = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               mdu_hi = pend_hi; mdu_lo = pend_lo;
            end
         end
         if (!reset) begin
            case (mdu_op)
               4'd1, 4'd2: {pend_hi, pend_lo} = {32'd0, mdu_a} * {32'd0, mdu_b};
               4'd3, 4'd4: begin
                  pend_hi = mdu_a % mdu_b;
                  pend_lo = mdu_a / mdu_b;
               end
               4'd5: mdu_hi = mdu_a;
               4'd6: mdu_lo = mdu_a;
               default: ;
            endcase
            if (mdu_op >= 4'd1 && mdu_op <= 4'd4) begin
               busy_left = next_lat;
               if (next_lat == 0) begin
                  mdu_hi = pend_hi; mdu_lo = pend_lo;
               end
            end
         end
         mdu_busy = (busy_left > 0);
      end
   end

   // Monitor: every issue pulse and every read result must match the head of its queue.
   initial begin
      iss_t e;
      forever begin
         @(negedge clk);
         if (!reset && mdu_op != 4'd0) begin
            if (exp_iss.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_issue: got op %0d expected none", mdu_op);
            end else begin
               e = exp_iss.pop_front();
               check("issue_op", {60'd0, mdu_op}, {60'd0, e.op});
               check("issue_a", {32'd0, mdu_a}, {32'd0, e.a});
               check("issue_b", {32'd0, mdu_b}, {32'd0, e.b});
            end
         end
         if (!reset && mf_valid) begin
            if (exp_mf.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_mf: got %0h expected none", mf_data);
            end else begin
               check("mf_data", {32'd0, mf_data}, {32'd0, exp_mf.pop_front()});
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int guard;
      reset = 1'b1; e_valid = 1'b0; e_op = 4'd0; e_rs = 32'd0; e_rt = 32'd0; e_flush = 1'b0;

      // Reset for three cycles; a read op presented now must not stall (IDLE, unit idle).
      step(3);
      e_valid = 1'b1; e_op = 4'd7;
      @(negedge clk);
      check("rst_mdu_op", {60'd0, mdu_op}, 64'd0);
      check("rst_mdu_a", {32'd0, mdu_a}, 64'd0);
      check("rst_mdu_b", {32'd0, mdu_b}, 64'd0);
      check("rst_mf_valid", {63'd0, mf_valid}, 64'd0);
      check("rst_mf_data", {32'd0, mf_data}, 64'd0);
      check("rst_timeout", {63'd0, timeout}, 64'd0);
      check("rst_last_lat", {59'd0, last_lat}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      step(1);
      reset = 1'b0; e_valid = 1'b0; e_op = 4'd0;
      step(1);

      // mult 233*2, busy 5 cycles, then mflo after completion.
      next_lat = 5;
      exp_iss.push_back('{4'd1, 32'd233, 32'd2});
      issue_op(4'd1, 32'd233, 32'd2, s);
      check("mult_stall", s, 64'd0);
      step(10);
      check("mult_last_lat", {59'd0, last_lat}, 64'd5);
      exp_mf.push_back(32'd466);
      issue_op(4'd8, 32'd0, 32'd0, s);
      check("mflo_stall", s, 64'd0);
      step(2);

      // div 100/7 immediately followed by mfhi: stalled for busy+2 cycles.
      next_lat = 6;
      exp_iss.push_back('{4'd3, 32'd100, 32'd7});
      issue_op(4'd3, 32'd100, 32'd7, s);
      exp_mf.push_back(32'd2);
      issue_op(4'd7, 32'd0, 32'd0, s);
      check("div_mfhi_stall", s, 64'd8);
      check("div_last_lat", {59'd0, last_lat}, 64'd6);
      step(2);

      // divu where busy never rises: completes after two WAIT cycles with latency 0.
      next_lat = 0;
      exp_iss.push_back('{4'd4, 32'd9, 32'd3});
      issue_op(4'd4, 32'd9, 32'd3, s);
      exp_mf.push_back(32'd3);
      issue_op(4'd8, 32'd0, 32'd0, s);
      check("nobusy_stall", s, 64'd4);
      check("nobusy_last_lat", {59'd0, last_lat}, 64'd0);
      step(2);

      // Back-to-back long ops: second waits busy+2 cycles, pulses busy+3 apart.
      next_lat = 3;
      exp_iss.push_back('{4'd2, 32'hFFFF_FFFF, 32'd2});
      issue_op(4'd2, 32'hFFFF_FFFF, 32'd2, s);
      exp_iss.push_back('{4'd2, 32'd7, 32'd6});
      issue_op(4'd2, 32'd7, 32'd6, s);
      check("b2b_stall", s, 64'd5);
      exp_mf.push_back(32'd42);
      issue_op(4'd8, 32'd0, 32'd0, s);
      check("b2b_mflo_stall", s, 64'd5);
      step(2);

      // mthi: one ISSUE cycle, then a following op is not stalled.
      exp_iss.push_back('{4'd5, 32'hDEAD_BEEF, 32'd0});
      issue_op(4'd5, 32'hDEAD_BEEF, 32'd0, s);
      step(1);
      exp_mf.push_back(32'hDEAD_BEEF);
      issue_op(4'd7, 32'd0, 32'd0, s);
      check("mthi_next_stall", s, 64'd0);
      exp_iss.push_back('{4'd6, 32'h1234_5678, 32'd0});
      issue_op(4'd6, 32'h1234_5678, 32'd0, s);
      exp_mf.push_back(32'h1234_5678);
      issue_op(4'd8, 32'd0, 32'd0, s);
      check("mtlo_mflo_stall", s, 64'd1);
      step(2);

      // Flushed divu and flushed mfhi: no stall, no issue, no read result.
      e_valid = 1'b1; e_op = 4'd4; e_rs = 32'd50; e_rt = 32'd5; e_flush = 1'b1;
      @(negedge clk);
      check("flush_divu_stall", {63'd0, stall}, 64'd0);
      step(1);
      e_op = 4'd7;
      @(negedge clk);
      check("flush_mfhi_stall", {63'd0, stall}, 64'd0);
      step(1);
      e_valid = 1'b0; e_op = 4'd0; e_flush = 1'b0;
      step(3);
      @(negedge clk);
      check("flush_mdu_op", {60'd0, mdu_op}, 64'd0);
      step(1);

      // mult with reset on the second WAIT cycle while busy stays high for 20 cycles.
      next_lat = 20;
      exp_iss.push_back('{4'd1, 32'd3, 32'd4});
      issue_op(4'd1, 32'd3, 32'd4, s);
      step(1);
      step(1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      e_valid = 1'b1; e_op = 4'd1; e_rs = 32'd5; e_rt = 32'd5;
      @(negedge clk);
      check("postrst_stall", {63'd0, stall}, 64'd1);
      check("postrst_last_lat", {59'd0, last_lat}, 64'd0);
      check("postrst_mf_data", {32'd0, mf_data}, 64'd0);
      step(1);
      e_valid = 1'b0; e_op = 4'd0;
      guard = 0;
      while (mdu_busy && guard < 100) begin
         step(1);
         guard++;
      end
      check("postrst_busy_drop", {63'd0, mdu_busy}, 64'd0);
      check("postrst_timeout", {63'd0, timeout}, 64'd0);
      step(2);

      // Same stimulus without reset: busy outlasts MAX_WAIT and sets the sticky timeout.
      exp_iss.push_back('{4'd1, 32'd1, 32'd1});
      issue_op(4'd1, 32'd1, 32'd1, s);
      guard = 0;
      while (mdu_busy && guard < 100) begin
         step(1);
         guard++;
      end
      step(2);
      check("timeout_set", {63'd0, timeout}, 64'd1);
      step(5);
      check("timeout_sticky", {63'd0, timeout}, 64'd1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      @(negedge clk);
      check("timeout_cleared", {63'd0, timeout}, 64'd0);
      step(3);

      check("iss_queue_empty", exp_iss.size(), 64'd0);
      check("mf_queue_empty", exp_mf.size(), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
